alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle 32-bit ALU.
- Keeps opcodes 0–9 at 1-cycle registered latency.
- Adds iterative unsigned MUL/DIVU/REMU, a start/busy/done handshake, and status flags.
- Sits in the execute stage; the core controller stalls on busy.

Parameters:
- WIDTH, 32, operand and result width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  launch request; sampled only when busy=0.
- ctrlALU  in  4  opcode.
- dataIn0  in  WIDTH  operand A.
- dataIn1  in  WIDTH  operand B.
- busy  out  1  iterative operation in progress.
- done  out  1  one-cycle pulse: result valid.
- dataOut  out  WIDTH  result; held until next done.
- cmp  out  1  compare result (op 9); held with dataOut.
- flagZ  out  1  dataOut==0; held.
- flagC  out  1  carry (ADD), borrow (SUB), high-half-nonzero (MUL); else 0.
- flagDz  out  1  divide by zero (DIVU/REMU).
- flagIll  out  1  illegal opcode 13–15.

Behaviour:
- Reset: all outputs 0, FSM → IDLE, counter 0. Reset mid-operation aborts; no done pulse.
- Opcodes, all unsigned unless noted:
  - 0 ADD, 1 SUB (A−B mod 2^WIDTH), 2 AND, 3 OR, 4 XOR, 5 NOT A.
  - 6 SHL A by B[CNT_W-2:0], 7 SHR logical, 8 SAR arithmetic.
  - 9 CMP: cmp=(A==B), dataOut=0.
  - 10 MUL: low WIDTH bits of A*B. 11 DIVU: A/B. 12 REMU: A%B.
- FSM states: IDLE, ITER, FIN.
  - IDLE, start=1, op 0–9 or 13–15: compute, register outputs, done=1 next cycle. Stay IDLE; latency 1, back-to-back starts allowed.
  - IDLE, start=1, op 10–12, B≠0: latch operands, counter=0, busy=1 next cycle, → ITER.
  - IDLE, start=1, op 11/12 with B==0: latency 1, no ITER. DIVU returns all-ones, REMU returns A; flagDz=1.
  - ITER: one bit per cycle.
    - MUL: shift-add over 2*WIDTH accumulator.
    - DIVU/REMU: restoring divide, remainder WIDTH+1 bits.
    - Counter increments each cycle; after WIDTH iterations → FIN.
  - FIN: register result and flags, done=1, busy=0. → IDLE next cycle.
- Iterative latency: done exactly WIDTH+1 cycles after the start cycle. busy is high for WIDTH cycles.
- start while busy=1: ignored; operands and ctrlALU changes have no effect.
- Flags:
  - cmp, flagDz and flagIll are 0 on every done except their defining case.
  - flagZ is always recomputed from the new dataOut.
- dataOut and flags change only on a done cycle or on reset.
- Illegal op: dataOut=0, flagIll=1, flagZ=1.
- Shift amount ≥ WIDTH cannot occur (masked to CNT_W-1 bits, max WIDTH−1).

Decomposition:
- Package alu_pkg:
  - opcode enum OP_ADD..OP_REMU (4-bit).
  - state enum IDLE/ITER/FIN.
  - constant OP_ITER_FIRST=10.
- Sub-module alu_iter_core: shift-add multiply / restoring divide engine.
  - Inputs: load, mode, A, B.
  - Outputs: fin pulse, quotient/product-low, remainder, product-high-nonzero.
- alu_mc holds the single-cycle datapath, FSM and output registers.

Test Plan:
- WIDTH=32, start op0 A=8 B=5 → next cycle done=1, dataOut=13, flagC=0; op1 A=5 B=8 → dataOut=0xFFFFFFFD, flagC=1.
- op9 A=10 B=5 → cmp=0, flagZ=1; op9 A=5 B=5 → cmp=1; back-to-back starts give done on consecutive cycles.
- op10 A=0x10000 B=0x10001 → busy high 32 cycles, done at cycle 33, dataOut=0x00010000, flagC=1; start pulses during busy ignored.
- op11 A=100 B=7 → dataOut=14 at cycle 33; op12 same operands → dataOut=2; op11 B=0 → latency 1, dataOut=0xFFFFFFFF, flagDz=1.
- rst asserted at cycle 10 of a DIVU → outputs 0 next cycle, no done; a new op0 start then completes normally.
- WIDTH=8 instance: op10 A=15 B=17 → dataOut=0xFF at cycle 9, flagC=0; op8 A=0x80 B=3 → 0xF0; op14 → flagIll=1, dataOut=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and iteration-mode definitions for the multi-cycle ALU.
// Opcodes 13-15 are deliberately absent from op_e: they decode as illegal.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOT  = 4'd5,
        OP_SHL  = 4'd6,
        OP_SHR  = 4'd7,
        OP_SAR  = 4'd8,
        OP_CMP  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    localparam logic [3:0] OP_ITER_FIRST = 4'd10;
    localparam logic [3:0] OP_ILL_FIRST  = 4'd13;

    function automatic logic is_iter_op(input logic [3:0] op);
        return (op >= OP_ITER_FIRST) && (op < OP_ILL_FIRST);
    endfunction

endpackage

// File: rtl/alu_iter_core.sv
// Bit-serial engine: shift-add multiply or restoring divide, one bit per cycle.
// Results are presented combinationally during the final iteration (fin_o high).
module alu_iter_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  iter_mode_e       mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             fin_o,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] r_o,
    output logic             hi_nz_o
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             active_q, active_d;
    iter_mode_e       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] hi_step;
    logic [WIDTH-1:0] lo_step;

    // hi:lo is the 2*WIDTH product accumulator, or remainder:quotient when dividing.
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        rem_sh  = {hi_q, lo_q[WIDTH-1]};
        hi_step = hi_q;
        lo_step = lo_q;
        if (mode_q == MODE_MUL) begin
            hi_step = mul_sum[WIDTH:1];
            lo_step = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (rem_sh >= {1'b0, b_q}) begin
            hi_step = rem_sh[WIDTH-1:0] - b_q;
            lo_step = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
            hi_step = rem_sh[WIDTH-1:0];
            lo_step = {lo_q[WIDTH-2:0], 1'b0};
        end
    end

    assign fin_o   = active_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign q_o     = lo_step;
    assign r_o     = hi_step;
    assign hi_nz_o = |hi_step;

    always_comb begin
        active_d = active_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        if (load_i) begin
            active_d = 1'b1;
            mode_d   = mode_i;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a_i;
            b_d      = b_i;
        end else if (active_q) begin
            hi_d  = hi_step;
            lo_d  = lo_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (fin_o) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            mode_q   <= MODE_MUL;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
        end else begin
            active_q <= active_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Execute-stage ALU: single-cycle ops register in one cycle, MUL/DIVU/REMU run
// on alu_iter_core for WIDTH cycles with busy high; done pulses once per result.
module alu_mc
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ctrlALU,
    input  logic [WIDTH-1:0] dataIn0,
    input  logic [WIDTH-1:0] dataIn1,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataOut,
    output logic             cmp,
    output logic             flagZ,
    output logic             flagC,
    output logic             flagDz,
    output logic             flagIll
);

    state_e           state_q, state_d;
    logic             accept, launch, sc_en, fin_en;
    iter_mode_e       core_mode;
    logic             core_fin, core_hi_nz;
    logic [WIDTH-1:0] core_q, core_r;

    logic [WIDTH:0]   sum_w, diff_w;
    logic [CNT_W-2:0] sh;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_cmp, sc_dz, sc_ill;

    logic [WIDTH-1:0] it_res;
    logic             it_c;

    logic [3:0]       it_op_q, it_op_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             done_q, done_d;
    logic             cmp_q, cmp_d;
    logic             z_q, z_d;
    logic             c_q, c_d;
    logic             dz_q, dz_d;
    logic             ill_q, ill_d;

    // Single-cycle datapath; DIVU/REMU entries only matter for the divide-by-zero bypass.
    always_comb begin
        sum_w  = {1'b0, dataIn0} + {1'b0, dataIn1};
        diff_w = {1'b0, dataIn0} - {1'b0, dataIn1};
        sh     = dataIn1[CNT_W-2:0];
        sc_res = '0;
        sc_c   = 1'b0;
        sc_cmp = 1'b0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        case (ctrlALU)
            OP_ADD: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
            end
            OP_SUB: begin
                sc_res = diff_w[WIDTH-1:0];
                sc_c   = diff_w[WIDTH];
            end
            OP_AND:  sc_res = dataIn0 & dataIn1;
            OP_OR:   sc_res = dataIn0 | dataIn1;
            OP_XOR:  sc_res = dataIn0 ^ dataIn1;
            OP_NOT:  sc_res = ~dataIn0;
            OP_SHL:  sc_res = dataIn0 << sh;
            OP_SHR:  sc_res = dataIn0 >> sh;
            OP_SAR:  sc_res = $unsigned($signed(dataIn0) >>> sh);
            OP_CMP:  sc_cmp = (dataIn0 == dataIn1);
            OP_MUL:  sc_res = '0;
            OP_DIVU: begin
                sc_res = '1;
                sc_dz  = 1'b1;
            end
            OP_REMU: begin
                sc_res = dataIn0;
                sc_dz  = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. FIN has busy low, so it accepts a new start like IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, FIN: state_d = launch ? ITER : IDLE;
            ITER:      state_d = core_fin ? FIN : ITER;
            default:   state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy      = (state_q == ITER);
        accept    = start && (state_q != ITER);
        launch    = accept && is_iter_op(ctrlALU)
                    && ((ctrlALU == OP_MUL) || (dataIn1 != '0));
        sc_en     = accept && !launch;
        fin_en    = (state_q == ITER) && core_fin;
        core_mode = (ctrlALU == OP_MUL) ? MODE_MUL : MODE_DIV;
    end

    alu_iter_core #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (launch),
        .mode_i  (core_mode),
        .a_i     (dataIn0),
        .b_i     (dataIn1),
        .fin_o   (core_fin),
        .q_o     (core_q),
        .r_o     (core_r),
        .hi_nz_o (core_hi_nz)
    );

    assign it_res = (it_op_q == OP_REMU) ? core_r : core_q;
    assign it_c   = (it_op_q == OP_MUL) && core_hi_nz;

    always_comb begin
        it_op_d = launch ? ctrlALU : it_op_q;
        out_d   = out_q;
        done_d  = 1'b0;
        cmp_d   = cmp_q;
        z_d     = z_q;
        c_d     = c_q;
        dz_d    = dz_q;
        ill_d   = ill_q;
        if (sc_en) begin
            out_d  = sc_res;
            done_d = 1'b1;
            cmp_d  = sc_cmp;
            z_d    = (sc_res == '0);
            c_d    = sc_c;
            dz_d   = sc_dz;
            ill_d  = sc_ill;
        end else if (fin_en) begin
            out_d  = it_res;
            done_d = 1'b1;
            cmp_d  = 1'b0;
            z_d    = (it_res == '0);
            c_d    = it_c;
            dz_d   = 1'b0;
            ill_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            it_op_q <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
            cmp_q   <= 1'b0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            dz_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            it_op_q <= it_op_d;
            out_q   <= out_d;
            done_q  <= done_d;
            cmp_q   <= cmp_d;
            z_q     <= z_d;
            c_q     <= c_d;
            dz_q    <= dz_d;
            ill_q   <= ill_d;
        end
    end

    assign done    = done_q;
    assign dataOut = out_q;
    assign cmp     = cmp_q;
    assign flagZ   = z_q;
    assign flagC   = c_q;
    assign flagDz  = dz_q;
    assign flagIll = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc at WIDTH=32 and WIDTH=8: directed vector table, hand sequences
// for back-to-back, reset abort and hold, then random ops against an arithmetic model.
module tb_alu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start32, busy32, done32, cmp32, z32, c32, dz32, ill32;
    logic [3:0]  ctrl32;
    logic [31:0] a32, b32, out32;

    logic        start8, busy8, done8, cmp8, z8, c8, dz8, ill8;
    logic [3:0]  ctrl8;
    logic [7:0]  a8, b8, out8;

    alu_mc #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .ctrlALU(ctrl32),
        .dataIn0(a32), .dataIn1(b32), .busy(busy32), .done(done32),
        .dataOut(out32), .cmp(cmp32), .flagZ(z32), .flagC(c32),
        .flagDz(dz32), .flagIll(ill32)
    );

    alu_mc #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .ctrlALU(ctrl8),
        .dataIn0(a8), .dataIn1(b8), .busy(busy8), .done(done8),
        .dataOut(out8), .cmp(cmp8), .flagZ(z8), .flagC(c8),
        .flagDz(dz8), .flagIll(ill8)
    );

    logic        use8;
    logic        cur_done, cur_busy, cur_cmp, cur_z, cur_c, cur_dz, cur_ill;
    logic [63:0] cur_out;

    always_comb begin
        if (use8) begin
            cur_done = done8; cur_busy = busy8; cur_cmp = cmp8; cur_z = z8;
            cur_c = c8; cur_dz = dz8; cur_ill = ill8; cur_out = {56'd0, out8};
        end else begin
            cur_done = done32; cur_busy = busy32; cur_cmp = cmp32; cur_z = z32;
            cur_c = c32; cur_dz = dz32; cur_ill = ill32; cur_out = {32'd0, out32};
        end
    end

    typedef struct {
        logic [63:0] res;
        logic        c;
        logic        cmp;
        logic        dz;
        logic        ill;
        int          lat;
    } exp_t;

    typedef struct {
        string       name;
        bit          w8;
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        exp_t        e;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on masked values.
    function automatic exp_t ref_model(input int w, input logic [3:0] op,
                                       input logic [63:0] a_in, input logic [63:0] b_in);
        exp_t        e;
        logic [63:0] mask, a, b, full;
        int          sh;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        sh = int'(b % 64'(w));
        e.res = 64'd0; e.c = 1'b0; e.cmp = 1'b0; e.dz = 1'b0; e.ill = 1'b0; e.lat = 1;
        case (op)
            4'd0: begin full = a + b; e.res = full & mask; e.c = |(full >> w); end
            4'd1: begin e.res = (a - b) & mask; e.c = (a < b); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = a ^ b;
            4'd5: e.res = ~a & mask;
            4'd6: e.res = (a << sh) & mask;
            4'd7: e.res = a >> sh;
            4'd8: begin
                if (((a >> (w - 1)) & 64'd1) == 64'd1)
                    e.res = ((a >> sh) | (mask & ~(mask >> sh))) & mask;
                else
                    e.res = a >> sh;
            end
            4'd9: e.cmp = (a == b);
            4'd10: begin
                full = a * b; e.res = full & mask; e.c = ((full >> w) != 64'd0); e.lat = w + 1;
            end
            4'd11: begin
                if (b == 64'd0) begin e.res = mask; e.dz = 1'b1; end
                else begin e.res = a / b; e.lat = w + 1; end
            end
            4'd12: begin
                if (b == 64'd0) begin e.res = a; e.dz = 1'b1; end
                else begin e.res = a % b; e.lat = w + 1; end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic vec_t mk(input string n, input bit w8, input logic [3:0] op,
                                input logic [63:0] a, input logic [63:0] b, input logic [63:0] res,
                                input logic c, input logic cmp_v, input logic dz,
                                input logic ill, input int lat);
        vec_t v;
        v.name = n; v.w8 = w8; v.op = op; v.a = a; v.b = b;
        v.e.res = res; v.e.c = c; v.e.cmp = cmp_v; v.e.dz = dz; v.e.ill = ill; v.e.lat = lat;
        return v;
    endfunction

    task automatic drive(input logic s, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        if (use8) begin
            start8 = s; ctrl8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = s; ctrl32 = op; a32 = a[31:0]; b32 = b[31:0];
        end
    endtask

    // Start one op, then wait (bounded) for done while throwing noise starts at the busy DUT.
    task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        drive(1'b1, op, a, b);
        @(negedge clk);
        drive(1'b0, op, a, b);
        lat = 1;
        bcnt = 0;
        while (!cur_done && lat < 200) begin
            bcnt += int'(cur_busy);
            if (cur_busy)
                drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      {$urandom, $urandom}, {$urandom, $urandom});
            else
                drive(1'b0, op, a, b);
            @(negedge clk);
            lat++;
        end
        drive(1'b0, op, a, b);
    endtask

    task automatic apply_and_check(input string name, input logic [3:0] op,
                                   input logic [63:0] a, input logic [63:0] b, input exp_t e);
        int lat, bcnt, w;
        w = use8 ? 8 : 32;
        issue(op, a, b, lat, bcnt);
        chk({name, " latency"}, 64'(lat), 64'(e.lat));
        chk({name, " busy_cycles"}, 64'(bcnt), (e.lat > 1) ? 64'(w) : 64'd0);
        chk({name, " dataOut"}, cur_out, e.res);
        chk({name, " flagC"}, 64'(cur_c), 64'(e.c));
        chk({name, " cmp"}, 64'(cur_cmp), 64'(e.cmp));
        chk({name, " flagZ"}, 64'(cur_z), 64'(e.res == 64'd0));
        chk({name, " flagDz"}, 64'(cur_dz), 64'(e.dz));
        chk({name, " flagIll"}, 64'(cur_ill), 64'(e.ill));
        @(negedge clk);
        chk({name, " done_pulse_end"}, 64'(cur_done), 64'd0);
        chk({name, " dataOut_held"}, cur_out, e.res);
    endtask

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        exp_t e;
        logic [3:0] op;
        logic [63:0] a, b;

        vecs.push_back(mk("add",       0, 4'd0,  64'd8,       64'd5,       64'd13,         0, 0, 0, 0, 1));
        vecs.push_back(mk("sub",       0, 4'd1,  64'd5,       64'd8,       64'hFFFFFFFD,   1, 0, 0, 0, 1));
        vecs.push_back(mk("cmp_ne",    0, 4'd9,  64'd10,      64'd5,       64'd0,          0, 0, 0, 0, 1));
        vecs.push_back(mk("cmp_eq",    0, 4'd9,  64'd5,       64'd5,       64'd0,          0, 1, 0, 0, 1));
        vecs.push_back(mk("mul32",     0, 4'd10, 64'h10000,   64'h10001,   64'h00010000,   1, 0, 0, 0, 33));
        vecs.push_back(mk("divu",      0, 4'd11, 64'd100,     64'd7,       64'd14,         0, 0, 0, 0, 33));
        vecs.push_back(mk("remu",      0, 4'd12, 64'd100,     64'd7,       64'd2,          0, 0, 0, 0, 33));
        vecs.push_back(mk("divu_zero", 0, 4'd11, 64'd100,     64'd0,       64'hFFFFFFFF,   0, 0, 1, 0, 1));
        vecs.push_back(mk("remu_zero", 0, 4'd12, 64'd100,     64'd0,       64'd100,        0, 0, 1, 0, 1));
        vecs.push_back(mk("shl_mask",  0, 4'd6,  64'd1,       64'd35,      64'd8,          0, 0, 0, 0, 1));
        vecs.push_back(mk("sar32",     0, 4'd8,  64'h80000000, 64'd31,     64'hFFFFFFFF,   0, 0, 0, 0, 1));
        vecs.push_back(mk("ill32",     0, 4'd14, 64'd3,       64'd4,       64'd0,          0, 0, 0, 1, 1));
        vecs.push_back(mk("mul8",      1, 4'd10, 64'd15,      64'd17,      64'hFF,         0, 0, 0, 0, 9));
        vecs.push_back(mk("sar8",      1, 4'd8,  64'h80,      64'd3,       64'hF0,         0, 0, 0, 0, 1));
        vecs.push_back(mk("ill8",      1, 4'd14, 64'd9,       64'd9,       64'd0,          0, 0, 0, 1, 1));
        vecs.push_back(mk("divu8",     1, 4'd11, 64'd200,     64'd7,       64'd28,         0, 0, 0, 0, 9));

        use8 = 1'b0;
        rst = 1'b1;
        start32 = 1'b0; ctrl32 = 4'd0; a32 = '0; b32 = '0;
        start8 = 1'b0; ctrl8 = 4'd0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        chk("reset busy32", 64'(busy32), 64'd0);
        chk("reset done32", 64'(done32), 64'd0);
        chk("reset dataOut32", 64'(out32), 64'd0);
        chk("reset flags32", 64'({cmp32, z32, c32, dz32, ill32}), 64'd0);
        chk("reset dataOut8", 64'(out8), 64'd0);
        chk("reset flags8", 64'({busy8, done8, cmp8, z8, c8, dz8, ill8}), 64'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            use8 = vecs[i].w8;
            apply_and_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);
        end

        // Back-to-back single-cycle starts
        use8 = 1'b0;
        @(negedge clk);
        drive(1'b1, 4'd0, 64'd1, 64'd1);
        @(negedge clk);
        chk("b2b add done", 64'(done32), 64'd1);
        chk("b2b add dataOut", 64'(out32), 64'd2);
        drive(1'b1, 4'd1, 64'd1, 64'd2);
        @(negedge clk);
        chk("b2b sub done", 64'(done32), 64'd1);
        chk("b2b sub dataOut", 64'(out32), 64'hFFFFFFFF);
        chk("b2b sub flagC", 64'(c32), 64'd1);
        drive(1'b1, 4'd9, 64'd7, 64'd7);
        @(negedge clk);
        chk("b2b cmp done", 64'(done32), 64'd1);
        chk("b2b cmp cmp", 64'(cmp32), 64'd1);
        chk("b2b cmp flagC", 64'(c32), 64'd0);
        drive(1'b0, 4'd3, 64'h1234, 64'h5678);
        repeat (3) begin
            @(negedge clk);
            drive(1'b0, 4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        chk("hold done", 64'(done32), 64'd0);
        chk("hold cmp", 64'(cmp32), 64'd1);
        chk("hold dataOut", 64'(out32), 64'd0);

        // Reset in the 10th cycle of a DIVU aborts it with no done
        @(negedge clk);
        drive(1'b1, 4'd11, 64'd100, 64'd7);
        @(negedge clk);
        drive(1'b0, 4'd11, 64'd100, 64'd7);
        repeat (9) @(negedge clk);
        chk("abort busy before rst", 64'(busy32), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort outputs", 64'({busy32, done32, cmp32, z32, c32, dz32, ill32}), 64'd0);
        chk("abort dataOut", 64'(out32), 64'd0);
        seen_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done32) seen_done++;
        end
        chk("abort no done", 64'(seen_done), 64'd0);
        e = ref_model(32, 4'd0, 64'd3, 64'd4);
        apply_and_check("after_abort add", 4'd0, 64'd3, 64'd4, e);

        // Random ops on both widths against the model
        repeat (60) begin
            use8 = 1'($urandom_range(0, 1));
            op = 4'($urandom_range(0, 15));
            a = {32'd0, $urandom};
            b = {32'd0, $urandom};
            if ($urandom_range(0, 3) == 0) b = 64'd0;
            if ($urandom_range(0, 3) == 0) b = b & 64'hF;
            e = ref_model(use8 ? 8 : 32, op, a, b);
            apply_and_check($sformatf("rand w%0d op%0d", use8 ? 8 : 32, op), op, a, b, e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
